// File: rtl/uart_rx_if.sv
// Receive-side bundle of the 8N1 UART link: serial line in, byte and status strobes out.
// slave is the receiver's view; master is the view of whoever drives the line and consumes bytes.
interface uart_rx_if;
    logic       i_RX_Serial;
    logic       o_RX_Active;
    logic       o_RX_DV;
    logic [7:0] o_RX_Byte;
    logic       o_RX_Frame_Err;

    modport master (
        output i_RX_Serial,
        input  o_RX_Active,
        input  o_RX_DV,
        input  o_RX_Byte,
        input  o_RX_Frame_Err
    );

    modport slave (
        input  i_RX_Serial,
        output o_RX_Active,
        output o_RX_DV,
        output o_RX_Byte,
        output o_RX_Frame_Err
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver, LSB first: oversamples a synchronised RX line and samples each bit mid-period.
// Emits a 1-cycle DV strobe with the byte, or a 1-cycle framing-error strobe on a low stop bit.
module uart_rx #(
    parameter int unsigned CLKS_PER_BIT = 434
) (
    input logic     i_Clock,
    input logic     i_Rst_L,
    uart_rx_if.slave rx_if
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT) + 1;
    localparam logic [CntW-1:0] HalfCnt = CntW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CntW-1:0] BitEnd  = CntW'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StData, StStop} state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] clk_cnt_q, clk_cnt_d;
    logic [2:0]      bit_idx_q, bit_idx_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      byte_q, byte_d;
    logic            dv_q, dv_d;
    logic            ferr_q, ferr_d;
    logic            active_q, active_d;
    logic            sync1_q, rx_s_q;

    // Two-flop synchroniser; resets to the idle (high) line level.
    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            sync1_q <= 1'b1;
            rx_s_q  <= 1'b1;
        end else begin
            sync1_q <= rx_if.i_RX_Serial;
            rx_s_q  <= sync1_q;
        end
    end

    always_ff @(posedge i_Clock or negedge i_Rst_L) begin
        if (!i_Rst_L) begin
            state_q   <= StIdle;
            clk_cnt_q <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            byte_q    <= '0;
            dv_q      <= 1'b0;
            ferr_q    <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_idx_q <= bit_idx_d;
            shift_q   <= shift_d;
            byte_q    <= byte_d;
            dv_q      <= dv_d;
            ferr_q    <= ferr_d;
            active_q  <= active_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = clk_cnt_q;
        bit_idx_d = bit_idx_q;
        shift_d   = shift_q;
        byte_d    = byte_q;
        dv_d      = 1'b0;
        ferr_d    = 1'b0;
        active_d  = active_q;

        case (state_q)
            StIdle: begin
                clk_cnt_d = '0;
                bit_idx_d = '0;
                if (!rx_s_q) begin
                    state_d  = StStart;
                    active_d = 1'b1;
                end
            end
            StStart: begin
                // Re-check the start bit at its midpoint to reject glitches.
                if (clk_cnt_q == HalfCnt) begin
                    clk_cnt_d = '0;
                    if (!rx_s_q) begin
                        state_d = StData;
                    end else begin
                        state_d  = StIdle;
                        active_d = 1'b0;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CntW'(1);
                end
            end
            StData: begin
                if (clk_cnt_q == BitEnd) begin
                    clk_cnt_d          = '0;
                    shift_d[bit_idx_q] = rx_s_q;
                    if (bit_idx_q == 3'd7) begin
                        state_d = StStop;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    clk_cnt_d = clk_cnt_q + CntW'(1);
                end
            end
            StStop: begin
                // Leave at mid-stop-bit so a back-to-back start edge is not missed.
                if (clk_cnt_q == BitEnd) begin
                    clk_cnt_d = '0;
                    if (rx_s_q) begin
                        byte_d = shift_q;
                        dv_d   = 1'b1;
                    end else begin
                        ferr_d = 1'b1;
                    end
                    state_d  = StIdle;
                    active_d = 1'b0;
                end else begin
                    clk_cnt_d = clk_cnt_q + CntW'(1);
                end
            end
            default: begin
                state_d   = StIdle;
                clk_cnt_d = '0;
                active_d  = 1'b0;
            end
        endcase
    end

    assign rx_if.o_RX_Active    = active_q;
    assign rx_if.o_RX_DV        = dv_q;
    assign rx_if.o_RX_Byte      = byte_q;
    assign rx_if.o_RX_Frame_Err = ferr_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx at 8 clocks/bit, plus 7 and 9 clocks/bit instances for the rate sweep.
// Good bytes are queued when sent and popped when the receiver strobes DV.
module tb_uart_rx;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    uart_rx_if rx_if ();
    uart_rx_if rx7_if ();
    uart_rx_if rx9_if ();

    uart_rx #(.CLKS_PER_BIT(8)) u_dut (.i_Clock(clk), .i_Rst_L(rst_n), .rx_if(rx_if));
    uart_rx #(.CLKS_PER_BIT(7)) u_dut7 (.i_Clock(clk), .i_Rst_L(rst_n), .rx_if(rx7_if));
    uart_rx #(.CLKS_PER_BIT(9)) u_dut9 (.i_Clock(clk), .i_Rst_L(rst_n), .rx_if(rx9_if));

    int errors = 0;
    int checks = 0;

    logic [7:0] exp_q[$];
    logic [7:0] sb_e;
    int cyc = 0;
    int dv_cnt = 0, fe_cnt = 0, act_cnt = 0;
    int last_dv_cyc = 0, prev_dv_cyc = 0;
    int dv7_cnt = 0, fe7_cnt = 0, dv9_cnt = 0, fe9_cnt = 0;
    logic [7:0] byte7 = 8'h00, byte9 = 8'h00;

    typedef struct {
        logic [7:0] data;
        logic       stop;
        logic       exp_dv;
        logic       exp_fe;
        logic [7:0] exp_byte;
    } vec_t;

    localparam int NV = 6;
    vec_t vecs[NV];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input int which, input logic v);
        case (which)
            7:       rx7_if.i_RX_Serial = v;
            9:       rx9_if.i_RX_Serial = v;
            default: rx_if.i_RX_Serial = v;
        endcase
    endtask

    // Drives start, 8 data bits LSB first, stop; line is left at the stop level.
    task automatic send_frame(input int which, input logic [7:0] b, input logic stop_v,
                              input int p);
        logic [9:0] bits;
        bits = {stop_v, b, 1'b0};
        for (int k = 0; k < 10; k++) begin
            set_line(which, bits[k]);
            idle(p);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rx_if.o_RX_Active) act_cnt++;
        if (rx_if.o_RX_Frame_Err) fe_cnt++;
        if (rx_if.o_RX_DV) begin
            dv_cnt++;
            prev_dv_cyc = last_dv_cyc;
            last_dv_cyc = cyc;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_dv: got byte %0h expected no strobe", rx_if.o_RX_Byte);
            end else begin
                sb_e = exp_q.pop_front();
                check("sb_byte", {24'd0, rx_if.o_RX_Byte}, {24'd0, sb_e});
            end
            check("dv_fe_exclusive", {31'd0, rx_if.o_RX_Frame_Err}, 32'd0);
        end
        if (rx7_if.o_RX_DV) begin
            dv7_cnt++;
            byte7 = rx7_if.o_RX_Byte;
        end
        if (rx7_if.o_RX_Frame_Err) fe7_cnt++;
        if (rx9_if.o_RX_DV) begin
            dv9_cnt++;
            byte9 = rx9_if.o_RX_Byte;
        end
        if (rx9_if.o_RX_Frame_Err) fe9_cnt++;
    end

    initial begin
        int dv0, fe0, a0;

        vecs[0] = '{data: 8'hA5, stop: 1'b1, exp_dv: 1'b1, exp_fe: 1'b0, exp_byte: 8'hA5};
        vecs[1] = '{data: 8'h00, stop: 1'b1, exp_dv: 1'b1, exp_fe: 1'b0, exp_byte: 8'h00};
        vecs[2] = '{data: 8'hFF, stop: 1'b1, exp_dv: 1'b1, exp_fe: 1'b0, exp_byte: 8'hFF};
        vecs[3] = '{data: 8'h5A, stop: 1'b1, exp_dv: 1'b1, exp_fe: 1'b0, exp_byte: 8'h5A};
        vecs[4] = '{data: 8'h3C, stop: 1'b0, exp_dv: 1'b0, exp_fe: 1'b1, exp_byte: 8'h5A};
        vecs[5] = '{data: 8'h96, stop: 1'b1, exp_dv: 1'b1, exp_fe: 1'b0, exp_byte: 8'h96};

        rst_n = 1'b0;
        set_line(0, 1'b1);
        set_line(7, 1'b1);
        set_line(9, 1'b1);
        repeat (3) @(negedge clk);
        check("rst_active", {31'd0, rx_if.o_RX_Active}, 32'd0);
        check("rst_dv", {31'd0, rx_if.o_RX_DV}, 32'd0);
        check("rst_fe", {31'd0, rx_if.o_RX_Frame_Err}, 32'd0);
        check("rst_byte", {24'd0, rx_if.o_RX_Byte}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        idle(5);

        // Active spans T0 .. T0+H+1+9*8 = 76 cycles for a good frame.
        for (int i = 0; i < NV; i++) begin
            dv0 = dv_cnt; fe0 = fe_cnt; a0 = act_cnt;
            if (vecs[i].exp_dv) exp_q.push_back(vecs[i].data);
            send_frame(0, vecs[i].data, vecs[i].stop, 8);
            set_line(0, 1'b1);
            idle(20);
            check($sformatf("vec%0d_dv", i), dv_cnt - dv0, {31'd0, vecs[i].exp_dv});
            check($sformatf("vec%0d_fe", i), fe_cnt - fe0, {31'd0, vecs[i].exp_fe});
            check($sformatf("vec%0d_byte", i), {24'd0, rx_if.o_RX_Byte},
                  {24'd0, vecs[i].exp_byte});
            if (vecs[i].exp_dv) check($sformatf("vec%0d_active", i), act_cnt - a0, 32'd76);
        end

        dv0 = dv_cnt; fe0 = fe_cnt;
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        send_frame(0, 8'h00, 1'b1, 8);
        send_frame(0, 8'hFF, 1'b1, 8);
        set_line(0, 1'b1);
        idle(20);
        check("b2b_dv", dv_cnt - dv0, 32'd2);
        check("b2b_fe", fe_cnt - fe0, 32'd0);
        check("b2b_gap", last_dv_cyc - prev_dv_cyc, 32'd80);

        dv0 = dv_cnt; fe0 = fe_cnt; a0 = act_cnt;
        set_line(0, 1'b0);
        idle(2);
        set_line(0, 1'b1);
        idle(20);
        check("glitch_dv", dv_cnt - dv0, 32'd0);
        check("glitch_fe", fe_cnt - fe0, 32'd0);
        check("glitch_active_len", {31'd0, (act_cnt - a0 >= 1) && (act_cnt - a0 <= 5)}, 32'd1);

        // Break of 156 clocks: errors at T0+76 and one frame period (77) later; the
        // third attempt sees the line high at mid-start and is dropped.
        dv0 = dv_cnt; fe0 = fe_cnt;
        set_line(0, 1'b0);
        idle(156);
        set_line(0, 1'b1);
        idle(30);
        check("break_fe", fe_cnt - fe0, 32'd2);
        check("break_dv", dv_cnt - dv0, 32'd0);
        check("break_byte", {24'd0, rx_if.o_RX_Byte}, 32'h00FF);

        dv0 = dv_cnt; fe0 = fe_cnt;
        fork
            send_frame(0, 8'hC3, 1'b1, 8);
            begin
                idle(44);
                rst_n = 1'b0;
            end
        join
        @(negedge clk);
        check("midrst_active", {31'd0, rx_if.o_RX_Active}, 32'd0);
        check("midrst_dv", {31'd0, rx_if.o_RX_DV}, 32'd0);
        check("midrst_fe", {31'd0, rx_if.o_RX_Frame_Err}, 32'd0);
        check("midrst_byte", {24'd0, rx_if.o_RX_Byte}, 32'd0);
        idle(3);
        rst_n = 1'b1;
        idle(10);
        exp_q.push_back(8'h81);
        send_frame(0, 8'h81, 1'b1, 8);
        set_line(0, 1'b1);
        idle(20);
        check("postrst_dv", dv_cnt - dv0, 32'd1);
        check("postrst_fe", fe_cnt - fe0, 32'd0);
        check("postrst_byte", {24'd0, rx_if.o_RX_Byte}, 32'h0081);

        fork
            send_frame(7, 8'h55, 1'b1, 7);
            send_frame(9, 8'h55, 1'b1, 9);
        join
        set_line(7, 1'b1);
        set_line(9, 1'b1);
        idle(20);
        check("rate7_dv", dv7_cnt, 32'd1);
        check("rate7_byte", {24'd0, byte7}, 32'h0055);
        check("rate7_fe", fe7_cnt, 32'd0);
        check("rate9_dv", dv9_cnt, 32'd1);
        check("rate9_byte", {24'd0, byte9}, 32'h0055);
        check("rate9_fe", fe9_cnt, 32'd0);

        check("sb_drained", exp_q.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
